// File: rtl/axi4_frame_writer.sv
// AXI4 write master: streams 64-bit packed pixels from a FWFT FIFO into DDR as
// 64-beat INCR bursts, one frame per double-buffer half, then hands the half to the reader.
module axi4_frame_writer #(
  parameter int                        AXI_ADDR_WIDTH   = 32,
  parameter int                        AXI_DATA_WIDTH   = 64,
  parameter int                        BURSTS_PER_FRAME = 300,
  parameter logic [AXI_ADDR_WIDTH-1:0] BUF0_ADDR        = 32'h0100_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] BUF1_ADDR        = 32'h0110_0000
) (
  input  logic                        clk_100Mhz,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic [AXI_DATA_WIDTH-1:0]   in_data,
  input  logic                        in_empty,
  input  logic                        in_burst_avail,
  output logic                        in_rd_en,
  output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [7:0]                  AWLEN,
  output logic [2:0]                  AWSIZE,
  output logic [1:0]                  AWBURST,
  output logic [3:0]                  AWCACHE,
  output logic [AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [7:0]                  WSTRB,
  output logic                        WVALID,
  input  logic                        WREADY,
  output logic                        WLAST,
  input  logic                        BVALID,
  output logic                        BREADY,
  input  logic [1:0]                  BRESP,
  output logic                        buf_select,
  output logic                        frame_done,
  output logic                        bresp_err,
  output logic                        sync_err,
  output logic [2:0]                  state,
  output logic [8:0]                  burst_idx
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_DATA  = 3'd1,
    ADDR_SEND  = 3'd2,
    DATA_WRITE = 3'd3,
    RESP_WAIT  = 3'd4,
    FRAME_END  = 3'd5
  } state_e;

  localparam logic [8:0] BPF = 9'(BURSTS_PER_FRAME);

  state_e                      state_q, state_d;
  logic [8:0]                  burst_idx_q, burst_idx_d;
  logic [5:0]                  beat_q, beat_d;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                        buf_sel_q, buf_sel_d;
  logic                        frame_done_q, frame_done_d;
  logic                        bresp_err_q, bresp_err_d;
  logic                        sync_err_q, sync_err_d;
  logic                        resync_q, resync_d;

  logic                        w_valid_s;
  logic                        w_hs_s;
  logic [8:0]                  burst_inc_s;
  logic [AXI_ADDR_WIDTH-1:0]   wr_base_s;

  assign w_valid_s   = (state_q == DATA_WRITE) & ~in_empty;
  assign w_hs_s      = w_valid_s & WREADY;
  assign burst_inc_s = burst_idx_q + 9'd1;
  // Always target the half the reader is not displaying.
  assign wr_base_s   = buf_sel_q ? BUF0_ADDR : BUF1_ADDR;

  assign AWADDR     = awaddr_q;
  assign AWVALID    = (state_q == ADDR_SEND);
  assign AWLEN      = 8'd63;
  assign AWSIZE     = 3'b011;
  assign AWBURST    = 2'b01;
  assign AWCACHE    = 4'b1111;
  assign WDATA      = in_data;
  assign WSTRB      = 8'hFF;
  assign WVALID     = w_valid_s;
  assign WLAST      = (beat_q == 6'd63) & w_valid_s;
  assign in_rd_en   = w_hs_s;
  assign BREADY     = (state_q == RESP_WAIT);
  assign buf_select = buf_sel_q;
  assign frame_done = frame_done_q;
  assign bresp_err  = bresp_err_q;
  assign sync_err   = sync_err_q;
  assign state      = state_q;
  assign burst_idx  = burst_idx_q;

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_idx_q  <= 9'd0;
      beat_q       <= 6'd0;
      awaddr_q     <= BUF1_ADDR;
      buf_sel_q    <= 1'b0;
      frame_done_q <= 1'b0;
      bresp_err_q  <= 1'b0;
      sync_err_q   <= 1'b0;
      resync_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_idx_q  <= burst_idx_d;
      beat_q       <= beat_d;
      awaddr_q     <= awaddr_d;
      buf_sel_q    <= buf_sel_d;
      frame_done_q <= frame_done_d;
      bresp_err_q  <= bresp_err_d;
      sync_err_q   <= sync_err_d;
      resync_q     <= resync_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_idx_d  = burst_idx_q;
    beat_d       = beat_q;
    awaddr_d     = awaddr_q;
    buf_sel_d    = buf_sel_q;
    frame_done_d = 1'b0;
    bresp_err_d  = bresp_err_q;
    sync_err_d   = sync_err_q;
    resync_d     = resync_q;

    // A frame_start seen while busy is remembered; the states below decide
    // when it can be honoured without breaking an in-flight burst.
    if (frame_start && (state_q != IDLE)) begin
      sync_err_d = 1'b1;
      resync_d   = 1'b1;
    end else begin
      sync_err_d = sync_err_q;
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          burst_idx_d = 9'd0;
          state_d     = WAIT_DATA;
        end else begin
          state_d = IDLE;
        end
      end

      WAIT_DATA: begin
        if (frame_start) begin
          // No burst in flight: restart the frame at once.
          burst_idx_d = 9'd0;
          resync_d    = 1'b0;
        end else if (in_burst_avail) begin
          awaddr_d = wr_base_s + AXI_ADDR_WIDTH'({burst_idx_q, 9'd0});
          state_d  = ADDR_SEND;
        end else begin
          state_d = WAIT_DATA;
        end
      end

      ADDR_SEND: begin
        if (AWREADY) begin
          beat_d  = 6'd0;
          state_d = DATA_WRITE;
        end else begin
          state_d = ADDR_SEND;
        end
      end

      DATA_WRITE: begin
        if (w_hs_s) begin
          beat_d = beat_q + 6'd1;
          if (beat_q == 6'd63) begin
            state_d = RESP_WAIT;
          end else begin
            state_d = DATA_WRITE;
          end
        end else begin
          state_d = DATA_WRITE;
        end
      end

      RESP_WAIT: begin
        if (BVALID) begin
          if (BRESP != 2'b00) begin
            bresp_err_d = 1'b1;
          end else begin
            bresp_err_d = bresp_err_q;
          end
          if (resync_q || frame_start) begin
            // Partial frame dropped; rewrite the same half from the top.
            burst_idx_d = 9'd0;
            resync_d    = 1'b0;
            state_d     = WAIT_DATA;
          end else if (burst_inc_s == BPF) begin
            burst_idx_d  = burst_inc_s;
            buf_sel_d    = ~buf_sel_q;
            frame_done_d = 1'b1;
            state_d      = FRAME_END;
          end else begin
            burst_idx_d = burst_inc_s;
            state_d     = WAIT_DATA;
          end
        end else begin
          state_d = RESP_WAIT;
        end
      end

      FRAME_END: begin
        burst_idx_d = 9'd0;
        resync_d    = 1'b0;
        if (frame_start) begin
          state_d = WAIT_DATA;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi4_frame_writer.sv
// Directed bench for axi4_frame_writer: FIFO and AXI slave models, address/data
// scoreboard, double-buffer hand-off, error flags, resync and async reset.
module tb_axi4_frame_writer;

  logic        clk_100Mhz = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [63:0] in_data;
  logic        in_empty;
  logic        in_burst_avail;
  logic        in_rd_en;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [3:0]  AWCACHE;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic        WLAST;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        buf_select;
  logic        frame_done;
  logic        bresp_err;
  logic        sync_err;
  logic [2:0]  state;
  logic [8:0]  burst_idx;

  axi4_frame_writer dut (
    .clk_100Mhz(clk_100Mhz), .rst(rst), .frame_start(frame_start),
    .in_data(in_data), .in_empty(in_empty), .in_burst_avail(in_burst_avail),
    .in_rd_en(in_rd_en), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWCACHE(AWCACHE),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .buf_select(buf_select),
    .frame_done(frame_done), .bresp_err(bresp_err), .sync_err(sync_err),
    .state(state), .burst_idx(burst_idx)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word(input int w);
    logic [15:0] p;
    p = 16'(w * 4);
    return {p + 16'd3, p + 16'd2, p + 16'd1, p};
  endfunction

  // Stimulus/model state
  bit          fast = 1'b1;
  int          err_burst = -1;
  int          cyc = 0;
  int          fifo_w = 0;
  int          exp_w = 0;
  int          beat = 0;
  int          exp_idx = 0;
  bit          exp_buf = 1'b0;
  bit          aw_open = 1'b0;
  bit          w_ok = 1'b0;
  int          aw_count = 0;
  int          b_count = 0;
  int          rd_count = 0;
  int          whs_count = 0;
  int          fd_cycles = 0;
  logic [31:0] last_awaddr = 32'd0;
  int          last_b_cyc = 0;
  int          bufsel_cyc = 0;
  logic        prev_bufsel = 1'b0;
  logic        prev_awvalid = 1'b0;
  logic        prev_awready = 1'b0;
  logic [31:0] prev_awaddr = 32'd0;
  bit          last_b_hs = 1'b0;
  bit          last_wlast_hs = 1'b0;
  bit          pop_seen = 1'b0;
  bit          resync_exp = 1'b0;
  bit          resync_seen = 1'b0;
  bit          b_pending = 1'b0;
  int          b_delay = 0;

  // FIFO and AXI slave drive, just after each rising edge.
  always @(posedge clk_100Mhz) begin
    #1;
    cyc++;
    if (pop_seen) fifo_w++;
    in_data = word(fifo_w);
    AWREADY = fast ? 1'b1 : (cyc % 5 == 3);
    WREADY  = fast ? 1'b1 : (cyc % 9 != 4);
    in_empty = fast ? 1'b0 : (cyc % 16 == 7);
    if (rst) begin
      BVALID = 1'b0;
      b_pending = 1'b0;
    end else begin
      if (last_b_hs) begin
        BVALID = 1'b0;
        b_pending = 1'b0;
      end
      if (last_wlast_hs) begin
        b_pending = 1'b1;
        b_delay = fast ? 0 : (aw_count % 4);
      end
      if (b_pending && !BVALID) begin
        if (b_delay == 0) begin
          BVALID = 1'b1;
          BRESP = (exp_idx == err_burst) ? 2'b10 : 2'b00;
        end else begin
          b_delay--;
        end
      end
    end
  end

  // Protocol monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk_100Mhz) begin
    if (rst) begin
      pop_seen = 1'b0;
      last_b_hs = 1'b0;
      last_wlast_hs = 1'b0;
      prev_awvalid = 1'b0;
      aw_open = 1'b0;
      w_ok = 1'b0;
      beat = 0;
    end else begin
      pop_seen = in_rd_en;
      last_wlast_hs = 1'b0;
      if (in_rd_en) rd_count++;
      if (in_empty) check_eq("wvalid_when_empty", WVALID, 1'b0);
      if (prev_awvalid && !prev_awready) begin
        check_eq("aw_hold_valid", AWVALID, 1'b1);
        check_eq("aw_hold_addr", AWADDR, prev_awaddr);
      end
      if (AWVALID && AWREADY) begin
        check_eq("awaddr", AWADDR,
                 (exp_buf ? 32'h0100_0000 : 32'h0110_0000) + 32'(exp_idx) * 32'd512);
        check_eq("aw_while_outstanding", aw_open, 1'b0);
        aw_open = 1'b1;
        w_ok = 1'b1;
        aw_count++;
        last_awaddr = AWADDR;
      end
      if (WVALID) check_eq("w_before_aw", w_ok, 1'b1);
      if (WVALID && WREADY) begin
        whs_count++;
        check_eq("wdata", WDATA, word(exp_w));
        exp_w++;
        check_eq("wlast", WLAST, (beat == 63));
        if (beat == 63) begin
          last_wlast_hs = 1'b1;
          w_ok = 1'b0;
          beat = 0;
        end else begin
          beat++;
        end
      end
      last_b_hs = BVALID && BREADY;
      if (BVALID && BREADY) begin
        b_count++;
        aw_open = 1'b0;
        last_b_cyc = cyc;
        if (resync_exp) begin
          exp_idx = 0;
          resync_exp = 1'b0;
          resync_seen = 1'b1;
        end else begin
          exp_idx++;
          if (exp_idx == 300) begin
            exp_idx = 0;
            exp_buf = ~exp_buf;
          end
        end
      end
      if (frame_done) fd_cycles++;
      if (buf_select != prev_bufsel) bufsel_cyc = cyc;
      prev_bufsel = buf_select;
      prev_awvalid = AWVALID;
      prev_awready = AWREADY;
      prev_awaddr = AWADDR;
    end
  end

  task automatic pulse_start();
    @(posedge clk_100Mhz);
    #2 frame_start = 1'b1;
    @(posedge clk_100Mhz);
    #2 frame_start = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (fd_cycles < n && t < 60000) begin
      @(posedge clk_100Mhz);
      t++;
    end
    check_eq("frame_timeout", (t < 60000), 1'b1);
    repeat (5) @(posedge clk_100Mhz);
    #2;
  endtask

  initial begin
    int t;
    int aw_before;
    rst = 1'b1;
    frame_start = 1'b0;
    in_data = word(0);
    in_empty = 1'b0;
    in_burst_avail = 1'b1;
    AWREADY = 1'b1;
    WREADY = 1'b1;
    BVALID = 1'b0;
    BRESP = 2'b00;
    #12;
    check_eq("rst_state", state, 3'd0);
    check_eq("rst_buf_select", buf_select, 1'b0);
    check_eq("rst_awvalid", AWVALID, 1'b0);
    check_eq("rst_wvalid", WVALID, 1'b0);
    check_eq("rst_wlast", WLAST, 1'b0);
    check_eq("rst_bready", BREADY, 1'b0);
    check_eq("rst_rd_en", in_rd_en, 1'b0);
    check_eq("rst_frame_done", frame_done, 1'b0);
    check_eq("rst_bresp_err", bresp_err, 1'b0);
    check_eq("rst_sync_err", sync_err, 1'b0);
    check_eq("rst_burst_idx", burst_idx, 9'd0);
    check_eq("rst_awaddr", AWADDR, 32'h0110_0000);
    check_eq("const_aw", {AWLEN, AWSIZE, AWBURST, AWCACHE}, {8'd63, 3'b011, 2'b01, 4'b1111});
    check_eq("const_wstrb", WSTRB, 8'hFF);
    repeat (3) @(posedge clk_100Mhz);
    #2 rst = 1'b0;

    // FIFO full but no frame_start: must stay idle.
    repeat (20) @(posedge clk_100Mhz);
    #2;
    check_eq("idle_no_start_state", state, 3'd0);
    check_eq("idle_no_start_aw", aw_count, 0);

    // Frame A: zero-stall slave, writes half 1.
    pulse_start();
    wait_frames(1);
    check_eq("A_aw_count", aw_count, 300);
    check_eq("A_b_count", b_count, 300);
    check_eq("A_rd_count", rd_count, 19200);
    check_eq("A_whs_count", whs_count, 19200);
    check_eq("A_last_addr", last_awaddr, 32'h0112_5600);
    check_eq("A_buf_select", buf_select, 1'b1);
    check_eq("A_frame_done_width", fd_cycles, 1);
    check_eq("A_bufsel_after_b", bufsel_cyc - last_b_cyc, 1);
    check_eq("A_state_idle", state, 3'd0);
    check_eq("A_bresp_err", bresp_err, 1'b0);
    check_eq("A_sync_err", sync_err, 1'b0);

    // Frame B: stalls, FIFO gaps, SLVERR on burst 5; writes half 0.
    fast = 1'b0;
    err_burst = 5;
    pulse_start();
    wait_frames(2);
    err_burst = -1;
    check_eq("B_aw_count", aw_count, 600);
    check_eq("B_rd_count", rd_count, 38400);
    check_eq("B_whs_count", whs_count, 38400);
    check_eq("B_last_addr", last_awaddr, 32'h0102_5600);
    check_eq("B_buf_select", buf_select, 1'b0);
    check_eq("B_frame_done_width", fd_cycles, 2);
    check_eq("B_bufsel_after_b", bufsel_cyc - last_b_cyc, 1);
    check_eq("B_bresp_err", bresp_err, 1'b1);
    check_eq("B_sync_err", sync_err, 1'b0);

    // Frame C: frame_start during burst 100 beat 30 forces a restart.
    fast = 1'b1;
    pulse_start();
    t = 0;
    while (!(exp_idx == 100 && beat == 30) && t < 40000) begin
      @(posedge clk_100Mhz);
      t++;
    end
    check_eq("C_reach_burst100_timeout", (t < 40000), 1'b1);
    #1;
    frame_start = 1'b1;
    resync_exp = 1'b1;
    @(posedge clk_100Mhz);
    #2 frame_start = 1'b0;
    aw_before = aw_count;
    t = 0;
    while (!resync_seen && t < 1000) begin
      @(posedge clk_100Mhz);
      t++;
    end
    check_eq("C_resync_b_timeout", (t < 1000), 1'b1);
    check_eq("C_no_extra_aw", aw_count, aw_before);
    @(negedge clk_100Mhz);
    check_eq("C_sync_err", sync_err, 1'b1);
    check_eq("C_buf_select_kept", buf_select, 1'b0);
    check_eq("C_no_frame_done", fd_cycles, 2);
    t = 0;
    while (aw_count == aw_before && t < 1000) begin
      @(posedge clk_100Mhz);
      t++;
    end
    check_eq("C_next_aw_timeout", (t < 1000), 1'b1);
    check_eq("C_restart_addr", last_awaddr, 32'h0110_0000);
    check_eq("C_bresp_err_sticky", bresp_err, 1'b1);

    // Async reset in the middle of a data phase.
    t = 0;
    while (!(state == 3'd3 && beat == 10) && t < 1000) begin
      @(posedge clk_100Mhz);
      t++;
    end
    check_eq("D_reach_data_timeout", (t < 1000), 1'b1);
    @(negedge clk_100Mhz);
    check_eq("D_pre_rst_wvalid", WVALID, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("D_rst_awvalid", AWVALID, 1'b0);
    check_eq("D_rst_wvalid", WVALID, 1'b0);
    check_eq("D_rst_bready", BREADY, 1'b0);
    check_eq("D_rst_rd_en", in_rd_en, 1'b0);
    check_eq("D_rst_frame_done", frame_done, 1'b0);
    check_eq("D_rst_state", state, 3'd0);
    check_eq("D_rst_sync_err", sync_err, 1'b0);
    check_eq("D_rst_bresp_err", bresp_err, 1'b0);
    check_eq("D_rst_buf_select", buf_select, 1'b0);
    @(posedge clk_100Mhz);
    #2 rst = 1'b0;
    aw_before = aw_count;
    repeat (20) @(posedge clk_100Mhz);
    #2;
    check_eq("D_idle_after_rst", state, 3'd0);
    check_eq("D_no_aw_after_rst", aw_count, aw_before);
    check_eq("D_burst_idx", burst_idx, 9'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
